anim_scheduler: RTL and testbench
=================================

ANIM_SCHEDULER -- requirements
Module: anim_scheduler

Interface
REQ-001 Parameter MOUTH_DIV, 4: frame ticks per mouth_state toggle (>=1).
REQ-002 Parameter GHOST_DIV, 8: frame ticks per ghost_phase toggle (>=1).
REQ-003 Parameter PELLET_DIV, 16: frame ticks per pellet_vis toggle (>=1).
REQ-004 Parameter FRIGHT_FRAMES, 360: frames spent in FRIGHT (>=1).
REQ-005 Parameter FLASH_FRAMES, 120: frames spent in FLASH (>=1).
REQ-006 Parameter FLASH_DIV, 8: frame ticks per ghost_flash toggle in FLASH (>=1).
REQ-007 clk_pix  in  1  pixel clock; the only clock.
REQ-008 rst  in  1  reset, synchronous, active-high.
REQ-009 vsync  in  1  vertical sync from VGA controller, clk_pix domain.
REQ-010 pause  in  1  level; freezes all animation and fright timing.
REQ-011 pac_moving  in  1  level; 0 freezes mouth animation only.
REQ-012 fright_start  in  1  single-cycle pulse; power pellet eaten.
REQ-013 frame_tick  out  1  single-cycle pulse per frame.
REQ-014 mouth_state  out  1  1=open, 0=closed.
REQ-015 ghost_phase  out  1  ghost leg animation frame.
REQ-016 pellet_vis  out  1  power pellet visible.
REQ-017 fright_state  out  2  NORMAL=0, FRIGHT=1, FLASH=2.
REQ-018 ghost_flash  out  1  1=draw frightened ghost white.

Function
REQ-019 Frame edge = vsync 1 this cycle and 0 previous cycle (vsync_d register); frame_tick SHALL assert the cycle after the edge is seen, for exactly one cycle.
REQ-020 All counters/outputs SHALL update on the same clock edge that asserts frame_tick; no other update point, except fright_start (REQ-026).
REQ-021 Each divider counts 0..DIV-1 on ticks; tick at DIV-1 wraps to 0 and toggles its output; DIV=1 toggles every tick; counter width $clog2(DIV) min 1.
REQ-022 frame_tick SHALL still pulse while pause=1; dividers and fright counter SHALL hold.
REQ-023 pac_moving=0 SHALL hold mouth counter and mouth_state; other channels unaffected.
REQ-024 fright_start in NORMAL: next state FRIGHT, remaining-frames counter loaded FRIGHT_FRAMES-1.
REQ-025 FRIGHT: each tick decrements; tick at 0 -> FLASH, counter loaded FLASH_FRAMES-1, ghost_flash cleared, flash divider cleared.
REQ-026 fright_start in FRIGHT or FLASH SHALL restart FRIGHT with full count; fright_start coinciding with a tick wins and that tick is not counted; accepted while paused.
REQ-027 FLASH: tick decrements, ghost_flash toggles per FLASH_DIV; tick at 0 -> NORMAL, ghost_flash 0.
REQ-028 ghost_flash SHALL be 0 whenever fright_state != FLASH; encoding 3 unreachable, SHALL recover to NORMAL next cycle.

Reset
REQ-029 rst SHALL clear: frame_tick, mouth_state, ghost_phase, ghost_flash to 0; pellet_vis to 1; fright_state NORMAL; all counters 0; vsync_d to 1 (no spurious edge if vsync high at reset release).
REQ-030 rst asserted mid-operation (any state, pending tick) SHALL take effect next edge and override all other inputs.

Configuration
REQ-031 ANIM_FLASH_EN defined: FLASH state as REQ-025..027.
REQ-032 ANIM_FLASH_EN undefined: FRIGHT tick at 0 -> NORMAL directly; FLASH never entered; ghost_flash tied 0; FLASH_FRAMES/FLASH_DIV unused.

Structure
REQ-033 Package anim_pkg SHALL hold fright_state_t enum and default divider/frame constants.
REQ-034 Sub-module anim_div (tick, enable, clear, toggling output) SHALL implement each divider; instantiated for mouth, ghost, pellet, flash.

Verification (bench: MOUTH_DIV=4, GHOST_DIV=2, PELLET_DIV=3, FRIGHT_FRAMES=3, FLASH_FRAMES=2, FLASH_DIV=1)
REQ-035 Release rst with vsync=1 -> no frame_tick; after 4 vsync rising edges mouth_state=1, ghost_phase toggled twice (0), pellet_vis 0 after edge 3.
REQ-036 pac_moving=0 for edges 1-4 then 1 -> mouth_state stays 0 until 4 further edges; ghost_phase unaffected.
REQ-037 fright_start -> FRIGHT; 3 ticks -> FLASH with ghost_flash toggling 1,0; 2 more ticks -> NORMAL, ghost_flash=0 (ANIM_FLASH_EN); undefined -> NORMAL after 3 ticks.
REQ-038 fright_start on same cycle as tick during FLASH -> FRIGHT, 3 further ticks needed to leave FRIGHT.
REQ-039 pause=1 across 5 edges -> 5 frame_tick pulses, all outputs and fright_state unchanged.
REQ-040 rst during FRIGHT -> next cycle fright_state NORMAL, pellet_vis 1, others 0.

Source files
------------

// File: rtl/anim_pkg.sv
// Shared types and default constants for the sprite animation scheduler.
package anim_pkg;

    typedef enum logic [1:0] {
        FS_NORMAL = 2'd0,
        FS_FRIGHT = 2'd1,
        FS_FLASH  = 2'd2
    } fright_state_t;

    localparam int unsigned DEF_MOUTH_DIV     = 4;
    localparam int unsigned DEF_GHOST_DIV     = 8;
    localparam int unsigned DEF_PELLET_DIV    = 16;
    localparam int unsigned DEF_FRIGHT_FRAMES = 360;
    localparam int unsigned DEF_FLASH_FRAMES  = 120;
    localparam int unsigned DEF_FLASH_DIV     = 8;

    // Bits needed to hold 0..n-1, never less than one.
    function automatic int unsigned cnt_w(input int unsigned n);
        return (n <= 1) ? 1 : $clog2(n);
    endfunction

endpackage

// File: rtl/anim_scheduler_if.sv
// Frame/animation signal bundle between the game controller and the scheduler.
interface anim_scheduler_if;
    import anim_pkg::*;

    logic          vsync;
    logic          pause;
    logic          pac_moving;
    logic          fright_start;
    logic          frame_tick;
    logic          mouth_state;
    logic          ghost_phase;
    logic          pellet_vis;
    fright_state_t fright_state;
    logic          ghost_flash;

    modport master (
        output vsync, pause, pac_moving, fright_start,
        input  frame_tick, mouth_state, ghost_phase, pellet_vis, fright_state, ghost_flash
    );

    modport slave (
        input  vsync, pause, pac_moving, fright_start,
        output frame_tick, mouth_state, ghost_phase, pellet_vis, fright_state, ghost_flash
    );

endinterface

// File: rtl/anim_div.sv
// Frame-tick divider: counts enabled ticks 0..DIV-1 and toggles its output on wrap.
module anim_div
    import anim_pkg::*;
#(
    parameter int unsigned DIV  = 2,
    parameter logic        INIT = 1'b0
) (
    input  logic clk,
    input  logic rst,
    input  logic tick,
    input  logic enable,
    input  logic clear,
    output logic toggle
);

    localparam int unsigned    CW   = cnt_w(DIV);
    localparam logic [CW-1:0]  LAST = CW'(DIV - 1);

    logic [CW-1:0] cnt;

    always_ff @(posedge clk) begin
        if (rst) begin
            cnt    <= '0;
            toggle <= INIT;
        end else if (clear) begin
            cnt    <= '0;
            toggle <= 1'b0;
        end else if (tick && enable) begin
            if (cnt == LAST) begin
                cnt    <= '0;
                toggle <= ~toggle;
            end else begin
                cnt <= cnt + CW'(1);
            end
        end
    end

endmodule

// File: rtl/anim_scheduler.sv
// Per-frame animation timing and power-pellet fright sequencing.
// Define ANIM_FLASH_EN to include the FLASH phase between FRIGHT and NORMAL.
module anim_scheduler
    import anim_pkg::*;
#(
    parameter int unsigned MOUTH_DIV     = DEF_MOUTH_DIV,
    parameter int unsigned GHOST_DIV     = DEF_GHOST_DIV,
    parameter int unsigned PELLET_DIV    = DEF_PELLET_DIV,
    parameter int unsigned FRIGHT_FRAMES = DEF_FRIGHT_FRAMES,
    parameter int unsigned FLASH_FRAMES  = DEF_FLASH_FRAMES,
    parameter int unsigned FLASH_DIV     = DEF_FLASH_DIV
) (
    input  logic              clk_pix,
    input  logic              rst,
    anim_scheduler_if.slave   bus
);

    localparam int unsigned MAX_FRAMES = (FRIGHT_FRAMES > FLASH_FRAMES) ? FRIGHT_FRAMES : FLASH_FRAMES;
    localparam int unsigned REM_W      = cnt_w(MAX_FRAMES);

    if (MOUTH_DIV < 1 || GHOST_DIV < 1 || PELLET_DIV < 1 ||
        FRIGHT_FRAMES < 1 || FLASH_FRAMES < 1 || FLASH_DIV < 1) begin : g_bad_param
        $error("anim_scheduler: all divider and frame parameters must be >= 1");
    end

    logic             vsync_d;
    logic             frame_edge_c;
    logic             adv_c;
    logic             mouth_run_c;
    logic             rem_zero_c;
    fright_state_t    state;
    logic [REM_W-1:0] rem;

    assign frame_edge_c = bus.vsync & ~vsync_d;
    assign adv_c        = frame_edge_c & ~bus.pause;
    assign mouth_run_c  = ~bus.pause & bus.pac_moving;
    assign rem_zero_c   = (rem == '0);

    // vsync_d resets high so a vsync already high at release is not an edge.
    always_ff @(posedge clk_pix) begin
        if (rst) begin
            vsync_d        <= 1'b1;
            bus.frame_tick <= 1'b0;
        end else begin
            vsync_d        <= bus.vsync;
            bus.frame_tick <= frame_edge_c;
        end
    end

    anim_div #(.DIV(MOUTH_DIV), .INIT(1'b0)) u_mouth (
        .clk(clk_pix), .rst(rst), .tick(frame_edge_c), .enable(mouth_run_c),
        .clear(1'b0), .toggle(bus.mouth_state)
    );

    anim_div #(.DIV(GHOST_DIV), .INIT(1'b0)) u_ghost (
        .clk(clk_pix), .rst(rst), .tick(frame_edge_c), .enable(~bus.pause),
        .clear(1'b0), .toggle(bus.ghost_phase)
    );

    anim_div #(.DIV(PELLET_DIV), .INIT(1'b1)) u_pellet (
        .clk(clk_pix), .rst(rst), .tick(frame_edge_c), .enable(~bus.pause),
        .clear(1'b0), .toggle(bus.pellet_vis)
    );

    // A new power pellet always restarts FRIGHT, even on a tick or while paused.
    always_ff @(posedge clk_pix) begin
        if (rst) begin
            state <= FS_NORMAL;
            rem   <= '0;
        end else if (bus.fright_start) begin
            state <= FS_FRIGHT;
            rem   <= REM_W'(FRIGHT_FRAMES - 1);
        end else begin
            case (state)
                FS_NORMAL: ;
                FS_FRIGHT: begin
                    if (adv_c) begin
                        if (rem_zero_c) begin
`ifdef ANIM_FLASH_EN
                            state <= FS_FLASH;
                            rem   <= REM_W'(FLASH_FRAMES - 1);
`else
                            state <= FS_NORMAL;
                            rem   <= '0;
`endif
                        end else begin
                            rem <= rem - REM_W'(1);
                        end
                    end
                end
                FS_FLASH: begin
                    if (adv_c) begin
                        if (rem_zero_c) begin
                            state <= FS_NORMAL;
                            rem   <= '0;
                        end else begin
                            rem <= rem - REM_W'(1);
                        end
                    end
                end
                default: begin
                    state <= FS_NORMAL;
                    rem   <= '0;
                end
            endcase
        end
    end

    assign bus.fright_state = state;

`ifdef ANIM_FLASH_EN
    logic flash_clr_c;

    // Held clear outside FLASH so it starts at 0 on entry and drops to 0 on exit.
    assign flash_clr_c = bus.fright_start | (state != FS_FLASH) | (adv_c & rem_zero_c);

    anim_div #(.DIV(FLASH_DIV), .INIT(1'b0)) u_flash (
        .clk(clk_pix), .rst(rst), .tick(frame_edge_c), .enable(~bus.pause),
        .clear(flash_clr_c), .toggle(bus.ghost_flash)
    );
`else
    assign bus.ghost_flash = 1'b0;
`endif

endmodule

// File: tb/tb_anim_scheduler.sv
// Directed plus randomized bench for anim_scheduler against a frame-count reference model.
module tb_anim_scheduler;
    import anim_pkg::*;

    localparam int unsigned MD = 4, GD = 2, PD = 3, FF = 3, FL = 2, FD = 1;
`ifdef ANIM_FLASH_EN
    localparam bit FLASH_EN = 1'b1;
`else
    localparam bit FLASH_EN = 1'b0;
`endif

    logic clk_pix = 1'b0;
    logic rst;

    anim_scheduler_if bus();

    anim_scheduler #(
        .MOUTH_DIV(MD), .GHOST_DIV(GD), .PELLET_DIV(PD),
        .FRIGHT_FRAMES(FF), .FLASH_FRAMES(FL), .FLASH_DIV(FD)
    ) dut (
        .clk_pix(clk_pix),
        .rst(rst),
        .bus(bus)
    );

    always #5 clk_pix = ~clk_pix;

    int n_cmp = 0;
    int n_bad = 0;
    int ticks_seen = 0;

    // Reference model: total enabled frame counts per channel plus fright bookkeeping.
    int   m_mouth_n, m_ghost_n, m_pellet_n, m_flash_n;
    int   m_fs, m_left;
    logic m_vs_prev, m_tick;

    task automatic chk(input string tag, input logic [1:0] obs, input logic [1:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_bad++;
            $error("FAIL %s: observed %0d expected %0d at %0t", tag, obs, exp, $time);
        end
    endtask

    task automatic model_step(input logic r, input logic vs, input logic ps,
                              input logic pm, input logic fs);
        logic edge_s, adv;
        if (r) begin
            m_vs_prev = 1'b1; m_tick = 1'b0;
            m_mouth_n = 0; m_ghost_n = 0; m_pellet_n = 0; m_flash_n = 0;
            m_fs = 0; m_left = 0;
        end else begin
            edge_s    = vs && !m_vs_prev;
            m_vs_prev = vs;
            m_tick    = edge_s;
            adv       = edge_s && !ps;
            if (adv) begin
                m_ghost_n++;
                m_pellet_n++;
                if (pm) m_mouth_n++;
            end
            if (fs) begin
                m_fs = 1; m_left = FF; m_flash_n = 0;
            end else if (adv && m_fs != 0) begin
                m_left--;
                if (m_fs == 2) m_flash_n++;
                if (m_left == 0) begin
                    if (m_fs == 1 && FLASH_EN) begin
                        m_fs = 2; m_left = FL;
                    end else begin
                        m_fs = 0;
                    end
                    m_flash_n = 0;
                end
            end
        end
    endtask

    task automatic chk_all();
        chk("frame_tick",   {1'b0, bus.frame_tick},  {1'b0, m_tick});
        chk("mouth_state",  {1'b0, bus.mouth_state}, 2'((m_mouth_n / MD) % 2));
        chk("ghost_phase",  {1'b0, bus.ghost_phase}, 2'((m_ghost_n / GD) % 2));
        chk("pellet_vis",   {1'b0, bus.pellet_vis},  2'(1 - (m_pellet_n / PD) % 2));
        chk("fright_state", bus.fright_state,        2'(m_fs));
        chk("ghost_flash",  {1'b0, bus.ghost_flash}, (m_fs == 2) ? 2'((m_flash_n / FD) % 2) : 2'd0);
    endtask

    task automatic cyc(input logic r, input logic vs, input logic ps, input logic pm, input logic fs);
        @(negedge clk_pix);
        rst = r; bus.vsync = vs; bus.pause = ps; bus.pac_moving = pm; bus.fright_start = fs;
        @(posedge clk_pix);
        model_step(r, vs, ps, pm, fs);
        #1;
        if (bus.frame_tick === 1'b1) ticks_seen++;
        chk_all();
    endtask

    // One frame: vsync low for two cycles, then high for two (one rising edge).
    task automatic frame(input logic ps, input logic pm);
        cyc(1'b0, 1'b0, ps, pm, 1'b0);
        cyc(1'b0, 1'b0, ps, pm, 1'b0);
        cyc(1'b0, 1'b1, ps, pm, 1'b0);
        cyc(1'b0, 1'b1, ps, pm, 1'b0);
    endtask

    task automatic do_reset();
        for (int i = 0; i < 3; i++) cyc(1'b1, 1'b1, 1'b0, 1'b1, 1'b0);
    endtask

    initial begin
        rst = 1'b1; bus.vsync = 1'b1; bus.pause = 1'b0; bus.pac_moving = 1'b1; bus.fright_start = 1'b0;
        model_step(1'b1, 1'b1, 1'b0, 1'b1, 1'b0);

        // Reset values and no spurious tick when vsync is high at release
        do_reset();
        chk("rst_pellet", {1'b0, bus.pellet_vis}, 2'd1);
        chk("rst_fright", bus.fright_state, 2'd0);
        ticks_seen = 0;
        for (int i = 0; i < 3; i++) cyc(1'b0, 1'b1, 1'b0, 1'b1, 1'b0);
        chk("no_spurious_tick", 2'(ticks_seen), 2'd0);

        // Basic divider behaviour over four frames
        for (int i = 0; i < 3; i++) frame(1'b0, 1'b1);
        chk("pellet_after_3", {1'b0, bus.pellet_vis}, 2'd0);
        frame(1'b0, 1'b1);
        chk("mouth_after_4", {1'b0, bus.mouth_state}, 2'd1);
        chk("ghost_after_4", {1'b0, bus.ghost_phase}, 2'd0);

        // pac_moving low holds only the mouth channel
        do_reset();
        for (int i = 0; i < 4; i++) frame(1'b0, 1'b0);
        chk("mouth_held", {1'b0, bus.mouth_state}, 2'd0);
        for (int i = 0; i < 3; i++) frame(1'b0, 1'b1);
        chk("mouth_not_yet", {1'b0, bus.mouth_state}, 2'd0);
        frame(1'b0, 1'b1);
        chk("mouth_resumed", {1'b0, bus.mouth_state}, 2'd1);

        // Fright sequence
        cyc(1'b0, 1'b1, 1'b0, 1'b1, 1'b1);
        chk("fright_entered", bus.fright_state, 2'd1);
        for (int i = 0; i < 3; i++) frame(1'b0, 1'b1);
        chk("after_fright", bus.fright_state, FLASH_EN ? 2'd2 : 2'd0);
        chk("flash_start", {1'b0, bus.ghost_flash}, 2'd0);
        frame(1'b0, 1'b1);
        chk("flash_toggled", {1'b0, bus.ghost_flash}, FLASH_EN ? 2'd1 : 2'd0);
        frame(1'b0, 1'b1);
        chk("back_normal", bus.fright_state, 2'd0);
        chk("flash_cleared", {1'b0, bus.ghost_flash}, 2'd0);

        // Restart coinciding with a tick: the tick is not counted
        cyc(1'b0, 1'b1, 1'b0, 1'b1, 1'b1);
        for (int i = 0; i < 3; i++) frame(1'b0, 1'b1);
        cyc(1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
        cyc(1'b0, 1'b1, 1'b0, 1'b1, 1'b1);
        chk("restart_on_tick", bus.fright_state, 2'd1);
        for (int i = 0; i < 2; i++) frame(1'b0, 1'b1);
        chk("still_fright", bus.fright_state, 2'd1);
        frame(1'b0, 1'b1);
        chk("left_fright", bus.fright_state, FLASH_EN ? 2'd2 : 2'd0);

        // Pause freezes everything but frame_tick; fright_start still accepted
        cyc(1'b0, 1'b1, 1'b1, 1'b1, 1'b1);
        ticks_seen = 0;
        for (int i = 0; i < 5; i++) frame(1'b1, 1'b1);
        chk("pause_ticks", 2'(ticks_seen / 2), 2'd2);
        chk("pause_ticks_lsb", 2'(ticks_seen % 2), 2'd1);
        chk("pause_fright", bus.fright_state, 2'd1);
        for (int i = 0; i < 3; i++) frame(1'b0, 1'b1);

        // Reset mid-FRIGHT, coinciding with an edge and fright_start
        cyc(1'b0, 1'b1, 1'b0, 1'b1, 1'b1);
        frame(1'b0, 1'b1);
        cyc(1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
        cyc(1'b1, 1'b1, 1'b0, 1'b1, 1'b1);
        chk("rst_mid_fright", bus.fright_state, 2'd0);
        chk("rst_mid_pellet", {1'b0, bus.pellet_vis}, 2'd1);
        chk("rst_mid_tick", {1'b0, bus.frame_tick}, 2'd0);

        // Randomized traffic
        for (int i = 0; i < 4000; i++) begin
            cyc(($urandom_range(0, 249) == 0),
                1'($urandom_range(0, 1)),
                ($urandom_range(0, 4) == 0),
                ($urandom_range(0, 3) != 0),
                ($urandom_range(0, 39) == 0));
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
